// File: rtl/truth_table_scanner_if.sv
// Signal bundle between a truth_table_scanner and the 3-input function it probes.
// master drives start/y_in; slave is the scanner itself.
interface truth_table_scanner_if;
   logic       start;
   logic       y_in;
   logic       a_out;
   logic       b_out;
   logic       c_out;
   logic       busy;
   logic       done;
   logic       valid;
   logic [7:0] table_out;
   logic [3:0] ones_count;
   logic       dep_a;
   logic       dep_b;
   logic       dep_c;

   modport master (
      output start, y_in,
      input  a_out, b_out, c_out, busy, done, valid,
      input  table_out, ones_count, dep_a, dep_b, dep_c
   );

   modport slave (
      input  start, y_in,
      output a_out, b_out, c_out, busy, done, valid,
      output table_out, ones_count, dep_a, dep_b, dep_c
   );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks all 8 minterms of a 3-input function, samples its response and publishes the table.
// Define SCANNER_DEPENDENCY_EN to build the per-variable dependency detectors (dep_* tied 0 otherwise).
module truth_table_scanner #(
   parameter int unsigned SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   truth_table_scanner_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state;
   state_t     state_next;
   logic [2:0] idx;
   logic [3:0] settle_cnt;
   logic [7:0] shadow;
   logic [7:0] shadow_next;
   logic [7:0] table_q;
   logic [3:0] ones_q;
   logic       valid_q;
   logic       capture;
   logic       scan_last;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      scan_last  = 1'b0;
      case (state)
         IDLE: if (bus.start) state_next = SCAN;
         SCAN: begin
            capture   = (settle_cnt == SETTLE_LAST);
            scan_last = capture && (idx == 3'd7);
            if (scan_last) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The final minterm is merged here so the result registers load it on the same edge.
   always_comb begin
      shadow_next = shadow;
      if (capture) shadow_next[idx] = bus.y_in;
   end

   // NOTE: the shadow table is a plain register, so it is reset like the rest of the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx        <= '0;
         settle_cnt <= '0;
         shadow     <= '0;
         table_q    <= '0;
         ones_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  idx        <= '0;
                  settle_cnt <= '0;
                  valid_q    <= 1'b0;
               end
            end
            SCAN: begin
               shadow <= shadow_next;
               if (capture) begin
                  settle_cnt <= '0;
                  if (scan_last) begin
                     table_q <= shadow_next;
                     ones_q  <= popcount8(shadow_next);
                     valid_q <= 1'b1;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SCANNER_DEPENDENCY_EN
   logic [2:0] dep_q;

   // A variable matters iff the two half-tables it selects between differ.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dep_q <= '0;
      end else if (scan_last) begin
         dep_q <= {(shadow_next[7:4] != shadow_next[3:0]),
                   ({shadow_next[7:6], shadow_next[3:2]} != {shadow_next[5:4], shadow_next[1:0]}),
                   ({shadow_next[7], shadow_next[5], shadow_next[3], shadow_next[1]} !=
                    {shadow_next[6], shadow_next[4], shadow_next[2], shadow_next[0]})};
      end
   end

   assign bus.dep_a = dep_q[2];
   assign bus.dep_b = dep_q[1];
   assign bus.dep_c = dep_q[0];
`else
   assign bus.dep_a = 1'b0;
   assign bus.dep_b = 1'b0;
   assign bus.dep_c = 1'b0;
`endif

   assign {bus.a_out, bus.b_out, bus.c_out} = (state == SCAN) ? idx : 3'b000;
   assign bus.busy       = (state == SCAN);
   assign bus.done       = (state == DONE);
   assign bus.valid      = valid_q;
   assign bus.table_out  = table_q;
   assign bus.ones_count = ones_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: two scanners (SETTLE=1 and SETTLE=3) driven by modelled functions,
// expected results queued at start and checked by a monitor on each done pulse.
module tb_truth_table_scanner;

   typedef struct packed {
      logic [7:0] tbl;
      logic [3:0] ones;
      logic [2:0] dep;
   } exp_t;

`ifdef SCANNER_DEPENDENCY_EN
   localparam bit DEP_EN = 1'b1;
`else
   localparam bit DEP_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   failures;
   int   mode1;
   int   mode3;

   exp_t q1[$];
   exp_t q3[$];
   bit   in_scan[2];
   int   start_cyc[2];
   logic [7:0] held_tbl[2];

   truth_table_scanner_if bus1();
   truth_table_scanner_if bus3();

   truth_table_scanner #(.SETTLE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
   truth_table_scanner #(.SETTLE(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

   // mode 0: const 0, 1: const 1, 2: (A&~B)|(A&C), 3: C
   function automatic logic yfun(input int mode, input logic a, input logic b, input logic c);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return (a & ~b) | (a & c);
         default: return c;
      endcase
   endfunction

   assign bus1.y_in = yfun(mode1, bus1.a_out, bus1.b_out, bus1.c_out);
   assign bus3.y_in = yfun(mode3, bus3.a_out, bus3.b_out, bus3.c_out);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] t, input logic [3:0] n, input logic [2:0] dep_on);
      exp_t e;
      e.tbl  = t;
      e.ones = n;
      e.dep  = DEP_EN ? dep_on : 3'b000;
      return e;
   endfunction

   task automatic mon(input int d, input int settle, input logic busy, input logic done,
                      input logic valid, input logic [2:0] stim, input logic [7:0] tbl,
                      input logic [3:0] ones, input logic [2:0] dep);
      exp_t e;
      bit   have;
      if (busy && !in_scan[d]) begin
         in_scan[d]   = 1'b1;
         start_cyc[d] = cyc;
      end
      if (busy) begin
         check($sformatf("stim_d%0d", d), 32'(stim), 32'((cyc - start_cyc[d]) / settle));
         check($sformatf("hold_tbl_d%0d", d), 32'(tbl), 32'(held_tbl[d]));
         check($sformatf("valid_low_d%0d", d), 32'(valid), 32'd0);
      end else begin
         check($sformatf("idle_stim_d%0d", d), 32'(stim), 32'd0);
      end
      if (done) begin
         in_scan[d] = 1'b0;
         have = 1'b0;
         if (d == 0) begin
            if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
         end else begin
            if (q3.size() > 0) begin have = 1'b1; e = q3.pop_front(); end
         end
         check($sformatf("done_expected_d%0d", d), 32'(have), 32'd1);
         if (have) begin
            check($sformatf("latency_d%0d", d), 32'(cyc - start_cyc[d]), 32'(8 * settle));
            check($sformatf("table_d%0d", d), 32'(tbl), 32'(e.tbl));
            check($sformatf("ones_d%0d", d), 32'(ones), 32'(e.ones));
            check($sformatf("dep_d%0d", d), 32'(dep), 32'(e.dep));
            check($sformatf("valid_d%0d", d), 32'(valid), 32'd1);
            check($sformatf("busy_in_done_d%0d", d), 32'(busy), 32'd0);
            held_tbl[d] = e.tbl;
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            in_scan[d]  = 1'b0;
            held_tbl[d] = 8'h00;
         end
      end else begin
         mon(0, 1, bus1.busy, bus1.done, bus1.valid, {bus1.a_out, bus1.b_out, bus1.c_out},
             bus1.table_out, bus1.ones_count, {bus1.dep_a, bus1.dep_b, bus1.dep_c});
         mon(1, 3, bus3.busy, bus3.done, bus3.valid, {bus3.a_out, bus3.b_out, bus3.c_out},
             bus3.table_out, bus3.ones_count, {bus3.dep_a, bus3.dep_b, bus3.dep_c});
      end
   end

   task automatic pulse1(input exp_t e);
      @(negedge clk);
      bus1.start = 1'b1;
      q1.push_back(e);
      @(negedge clk);
      bus1.start = 1'b0;
   endtask

   task automatic pulse3(input exp_t e);
      @(negedge clk);
      bus3.start = 1'b1;
      q3.push_back(e);
      @(negedge clk);
      bus3.start = 1'b0;
   endtask

   task automatic wait_done1(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus1.done) begin seen = 1'b1; break; end
      end
      check("done1_seen", 32'(seen), 32'd1);
   endtask

   task automatic wait_done3(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus3.done) begin seen = 1'b1; break; end
      end
      check("done3_seen", 32'(seen), 32'd1);
   endtask

   task automatic check_zero1(input string tag);
      check({tag, "_stim"},  32'({bus1.a_out, bus1.b_out, bus1.c_out}), 32'd0);
      check({tag, "_busy"},  32'(bus1.busy), 32'd0);
      check({tag, "_done"},  32'(bus1.done), 32'd0);
      check({tag, "_valid"}, 32'(bus1.valid), 32'd0);
      check({tag, "_table"}, 32'(bus1.table_out), 32'd0);
      check({tag, "_ones"},  32'(bus1.ones_count), 32'd0);
      check({tag, "_dep"},   32'({bus1.dep_a, bus1.dep_b, bus1.dep_c}), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      checks     = 0;
      failures   = 0;
      mode1      = 2;
      mode3      = 3;
      bus1.start = 1'b0;
      bus3.start = 1'b0;
      reset      = 1'b1;
      repeat (2) @(negedge clk);
      check_zero1("rst1");
      check("rst3_table", 32'(bus3.table_out), 32'd0);
      check("rst3_busy", 32'(bus3.busy), 32'd0);
      reset = 1'b0;

      // (A&~B)|(A&C) -> minterms 4,5,7
      mode1 = 2;
      pulse1(mk(8'hB0, 4'd3, 3'b111));
      wait_done1(40);

      mode1 = 0;
      pulse1(mk(8'h00, 4'd0, 3'b000));
      wait_done1(40);
      mode1 = 1;
      pulse1(mk(8'hFF, 4'd8, 3'b000));
      wait_done1(40);

      // start held high: back-to-back scans with one IDLE cycle between
      mode1 = 2;
      @(negedge clk);
      bus1.start = 1'b1;
      q1.push_back(mk(8'hB0, 4'd3, 3'b111));
      q1.push_back(mk(8'hB0, 4'd3, 3'b111));
      wait_done1(40);
      @(negedge clk);
      check("gap_idle_busy", 32'(bus1.busy), 32'd0);
      @(negedge clk);
      check("retrigger_busy", 32'(bus1.busy), 32'd1);
      bus1.start = 1'b0;
      wait_done1(40);

      // start pulses mid-scan are ignored and not queued
      pulse1(mk(8'hB0, 4'd3, 3'b111));
      repeat (2) @(negedge clk);
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      @(negedge clk);
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      wait_done1(40);
      repeat (2) begin
         @(negedge clk);
         check("no_queued_start", 32'(bus1.busy), 32'd0);
      end

      // asynchronous reset at idx=3, then a clean full scan
      pulse1(mk(8'hB0, 4'd3, 3'b111));
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ({bus1.a_out, bus1.b_out, bus1.c_out} == 3'd3) begin seen = 1'b1; break; end
      end
      check("reach_idx3", 32'(seen), 32'd1);
      #2;
      reset = 1'b1;
      q1.delete();
      #1;
      check_zero1("async_rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      pulse1(mk(8'hB0, 4'd3, 3'b111));
      wait_done1(40);

      // SETTLE=3 with y=C
      mode3 = 3;
      pulse3(mk(8'hAA, 4'd4, 3'b001));
      wait_done3(100);

      repeat (3) @(negedge clk);
      check("q1_drained", 32'(q1.size()), 32'd0);
      check("q3_drained", 32'(q3.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
